// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and bit timing.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_valid,
    output logic                       o_drop,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full = (count_q == CW'(DEPTH));

    // A full FIFO can still take a byte when the head leaves this cycle.
    always_comb begin
        pop_ok   = i_pop && (count_q != '0);
        push_ok  = i_push && (!full || pop_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        data_d   = data_q;
        if (count_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                data_d = i_wdata;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    assign o_rdata = data_q;
    assign o_valid = (count_q != '0);
    assign o_drop  = i_push && !push_ok;
    assign o_count = count_q;

endmodule

// File: rtl/receiver_uart.sv
// UART receiver: synchronizes RX, deframes 8N1 characters, queues bytes.
module receiver_uart
    import uart_pkg::*;
#(
    parameter int clk_freq_hz = 12000000,
    parameter int baud_rate   = 115200,
    parameter int fifo_depth  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_uart_rx,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_clear_err,
    output logic [$clog2(fifo_depth):0]   o_count
);

    localparam int CPB   = clks_per_bit(clk_freq_hz, baud_rate);
    localparam int CNT_W = $clog2(CPB);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              expired;
    logic              stop_hit;
    logic              push;
    logic              drop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= i_uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign expired  = (cnt_q == '0);
    assign stop_hit = (state_q == ST_STOP) && expired;
    assign push     = stop_hit && rx_s2_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        cnt_q   <= HALF_RELOAD;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (!expired) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (rx_s2_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q     <= FULL_RELOAD;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!expired) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shift_q   <= {rx_s2_q, shift_q[DATA_W-1:1]};
                        cnt_q     <= FULL_RELOAD;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!expired) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Setting a flag takes priority over clearing it.
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_clear_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (stop_hit && !rx_s2_q) begin
            frame_err_d = 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (push),
        .i_wdata (shift_q),
        .i_pop   (i_ready),
        .o_rdata (o_data),
        .o_valid (o_valid),
        .o_drop  (drop),
        .o_count (o_count)
    );

    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_receiver_uart.sv
// Bench for receiver_uart: frame-level model with a per-cycle compare.
module tb_receiver_uart;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int CPB   = clks_per_bit(12000000, 115200);
    localparam int LAT   = 3 + CPB / 2 + 9 * CPB;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn;
    logic          i_uart_rx;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_frame_err;
    logic          o_overrun;
    logic          i_clear_err;
    logic [CW-1:0] o_count;

    receiver_uart #(
        .clk_freq_hz (12000000),
        .baud_rate   (115200),
        .fifo_depth  (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_uart_rx   (i_uart_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clear_err (i_clear_err),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         rand_on = 1'b0;
    logic       rdy_e = 1'b0;
    logic       clr_e = 1'b0;
    logic       rst_e = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_e <= i_ready;
        clr_e <= i_clear_err;
        rst_e <= rstn;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s @cyc %0d: got %0h expected %0h",
                         nm, cyc, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: bytes land in the queue LAT edges after the start bit.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_e) begin
                mq.delete();
                evq.delete();
                m_fe = 1'b0;
                m_ov = 1'b0;
            end else begin
                bit pop_ok, set_fe, set_ov;
                pop_ok = rdy_e && (mq.size() > 0);
                set_fe = 1'b0;
                set_ov = 1'b0;
                if (pop_ok) void'(mq.pop_front());
                if (evq.size() > 0 && evq[0].at == cyc) begin
                    ev_t e;
                    e = evq.pop_front();
                    if (!e.ok) set_fe = 1'b1;
                    else if (mq.size() < DEPTH) mq.push_back(e.b);
                    else set_ov = 1'b1;
                end
                if (clr_e) begin
                    m_fe = 1'b0;
                    m_ov = 1'b0;
                end
                if (set_fe) m_fe = 1'b1;
                if (set_ov) m_ov = 1'b1;
            end
            chk("count", 32'(o_count), 32'(mq.size()));
            chk("valid", 32'(o_valid), 32'(mq.size() > 0));
            chk("frame_err", 32'(o_frame_err), 32'(m_fe));
            chk("overrun", 32'(o_overrun), 32'(m_ov));
            if (mq.size() > 0) chk("data", 32'(o_data), 32'(mq[0]));
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                             input bit rst_mid);
        i_uart_rx = 1'b0;
        if (!rst_mid) evq.push_back('{cyc + LAT, b, stop_ok});
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            if (rst_mid && i == 4) begin
                hold(40);
                rstn = 1'b0;
                hold(2);
                rstn = 1'b1;
                hold(CPB - 42);
            end else begin
                hold(CPB);
            end
        end
        i_uart_rx = stop_ok;
        hold(CPB);
        i_uart_rx = 1'b1;
    endtask

    task automatic pop_expect(input logic [7:0] e);
        chk("pop_valid", 32'(o_valid), 32'd1);
        chk("pop_data", 32'(o_data), 32'(e));
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic clear_pulse();
        i_clear_err = 1'b1;
        @(negedge clk);
        i_clear_err = 1'b0;
    endtask

    initial begin
        int p;
        i_uart_rx   = 1'b1;
        i_ready     = 1'b0;
        i_clear_err = 1'b0;
        rstn        = 1'b0;
        hold(3);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_flags", 32'({o_frame_err, o_overrun}), 32'd0);
        rstn = 1'b1;
        hold(10);

        send_byte(8'h55, 1'b1, 1'b0);
        hold(20);
        chk("single_count", 32'(o_count), 32'd1);
        pop_expect(8'h55);
        chk("single_empty", 32'(o_valid), 32'd0);

        i_uart_rx = 1'b0;
        hold(20);
        i_uart_rx = 1'b1;
        hold(300);
        chk("glitch_count", 32'(o_count), 32'd0);
        chk("glitch_flags", 32'({o_frame_err, o_overrun}), 32'd0);

        send_byte(8'hA5, 1'b0, 1'b0);
        hold(20);
        chk("ferr_set", 32'(o_frame_err), 32'd1);
        chk("ferr_count", 32'(o_count), 32'd0);
        clear_pulse();
        hold(2);
        chk("ferr_clear", 32'(o_frame_err), 32'd0);
        send_byte(8'h3C, 1'b1, 1'b0);
        hold(20);
        pop_expect(8'h3C);

        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 1'b0);
        hold(20);
        chk("ovr_count", 32'(o_count), 32'd4);
        chk("ovr_flag", 32'(o_overrun), 32'd1);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b));
        clear_pulse();
        hold(2);
        chk("ovr_clear", 32'(o_overrun), 32'd0);

        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        p = cyc + LAT;
        fork
            send_byte(8'h99, 1'b1, 1'b0);
            begin
                while (cyc < p - 1) @(negedge clk);
                i_ready = 1'b1;
                @(negedge clk);
                i_ready = 1'b0;
            end
        join
        hold(20);
        chk("fullpop_count", 32'(o_count), 32'd4);
        chk("fullpop_ovr", 32'(o_overrun), 32'd0);
        pop_expect(8'h22);
        pop_expect(8'h33);
        pop_expect(8'h44);
        pop_expect(8'h99);

        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'hF0, 1'b1, 1'b1);
        hold(20);
        chk("rstmid_count", 32'(o_count), 32'd0);
        chk("rstmid_data", 32'(o_data), 32'd0);
        send_byte(8'h0F, 1'b1, 1'b0);
        hold(20);
        chk("rstmid_next", 32'(o_count), 32'd1);
        pop_expect(8'h0F);

        rand_on = 1'b1;
        fork
            begin
                repeat (20) begin
                    hold($urandom_range(0, 200));
                    send_byte(8'($urandom), $urandom_range(0, 5) != 0, 1'b0);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(negedge clk);
                    i_ready     = ($urandom_range(0, 7) == 0);
                    i_clear_err = ($urandom_range(0, 63) == 0);
                end
                i_ready     = 1'b0;
                i_clear_err = 1'b0;
            end
        join
        hold(20);
        i_ready = 1'b1;
        hold(10);
        i_ready = 1'b0;
        clear_pulse();
        hold(5);
        chk("final_empty", 32'(o_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/receiver_uart.md
# receiver_uart

Receive half of the SoC's UART: oversamples the `RX` pin, deframes 8N1 characters and queues them in a small first-word-fall-through FIFO. It is the counterpart of `emitter_uart`, parameterised the same way (12 MHz, 115200 baud). It sits behind the memory-mapped IO decode: the data word is read through a `valid`/`ready` pop handshake, and error flags are exposed in the UART control word.

## Interface
- `clk_freq_hz`, 12000000: clock frequency in Hz.
- `baud_rate`, 115200: line rate. `CLKS_PER_BIT = clk_freq_hz / baud_rate`, integer division (104 at defaults).
- `fifo_depth`, 4: receive FIFO entries. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `i_uart_rx`  in  1  asynchronous serial input, idle high.
- `o_data`  out  8  FIFO head byte; valid only while `o_valid` = 1.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  pop; the head is consumed on a cycle where `o_valid && i_ready`.
- `o_frame_err`  out  1  sticky: a stop bit was sampled low.
- `o_overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `i_clear_err`  in  1  clears both sticky flags.
- `o_count`  out  $clog2(fifo_depth)+1  bytes held.

## Operation
- Input path: 2-FF synchronizer on `i_uart_rx`, then a 1-cycle history register for edge detection.
  - Both synchronizer stages and the history register reset to 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronized falling edge (prev 1, now 0), load the bit counter with `CLKS_PER_BIT/2 - 1` and go to START.
  - START: on counter expiry, sample the line.
    - If 1, the pulse was a glitch: go to IDLE.
    - If 0, reload the counter with `CLKS_PER_BIT - 1`, clear the bit index, go to DATA.
  - DATA: on each expiry, shift the sample into the MSB of the shift register (LSB-first on the wire) and reload the counter.
    - After the 8th sample, go to STOP.
  - STOP: on expiry, sample the stop bit.
    - If 1, push the shift register into the FIFO.
    - If 0, set `o_frame_err` and discard the byte.
    - Either way, go to IDLE. The FSM therefore re-arms at mid-stop-bit.
- Break or stuck-low line: no new start is detected until the line has returned high, because only falling edges trigger.
- FIFO push/pop:
  - A push into a full FIFO is accepted only if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `o_overrun` is set; existing contents are unchanged.
  - Push and pop on a non-full, non-empty FIFO: count is unchanged and order is preserved.
  - Pop while empty is ignored.
- Pointers are `$clog2(fifo_depth)` bits and wrap naturally. `o_count` = write count − read count.
- Sticky flag priority: set wins over `i_clear_err` in the same cycle.

## Timing
- Reset values:
  - FSM in IDLE; counters, shift register and FIFO pointers at 0.
  - `o_valid` = 0, `o_count` = 0, `o_frame_err` = 0, `o_overrun` = 0, `o_data` = 0.
- Reset mid-character: the partial byte is discarded and FIFO contents are lost. After `rstn` deasserts, the FSM waits for a fresh falling edge.
- Pin to detect: 2 cycles of synchronizer latency plus 1 cycle of edge detection.
- Sample points fall at 0.5, 1.5 … 9.5 bit times after the detected edge.
  - Total from detected edge to push ≈ `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles (988 at defaults).
- `o_valid` rises the cycle after the push. `o_data` is registered FIFO output (FWFT) and is stable while `o_valid && !i_ready`.
- Flag timing:
  - `o_frame_err`/`o_overrun` assert the cycle after the offending stop sample.
  - `i_clear_err` takes effect on the next edge.
- Back-to-back characters (stop bit directly followed by a start bit) are received without loss.

## Structure
- Shared package/include `uart_pkg`:
  - FSM state encoding.
  - `CLKS_PER_BIT` computation, common with `emitter_uart`.
  - Data width constant 8.
- One sub-module, `sync_fifo_fwft` (width, depth parameters): storage, pointers, count, and the push-while-full-with-pop rule.
- Synchronizer, FSM and flags live in `receiver_uart`.

## Test plan
- Single byte: drive 0x55 at 104 clk/bit → exactly one push; `o_valid` = 1, `o_data` = 0x55, `o_count` = 1; pop with `i_ready` → `o_valid` = 0.
- Glitch rejection: 20-cycle low pulse on an idle line → FSM returns to IDLE, no push, no flags.
- Frame error: 0xA5 with the stop bit held low → `o_frame_err` = 1, `o_count` stays 0; line high, then `i_clear_err` → flag clears; next 0x3C is received correctly.
- Overrun: 0x01–0x05 back-to-back with `i_ready` = 0 → `o_count` = 4, `o_overrun` = 1; pops return 0x01, 0x02, 0x03, 0x04.
- Full with simultaneous pop: FIFO full, `i_ready` = 1 exactly on the push cycle of 0x99 → no overrun, `o_count` stays 4, 0x99 is read last.
- Reset mid-byte: assert `rstn` = 0 for 2 cycles during bit 4 of 0xF0 → all outputs at reset values; the following 0x0F is received alone.
